// File: rtl/ddr2_host_pkg.sv
// ddr2_host_pkg: command codes, FSM states and burst helper shared
// by the DDR2 host-port responder model and its FIFO.
package ddr2_host_pkg;

  localparam logic [2:0] CMD_NOP = 3'b000;
  localparam logic [2:0] CMD_SCR = 3'b001;
  localparam logic [2:0] CMD_SCW = 3'b010;
  localparam logic [2:0] CMD_BLR = 3'b011;
  localparam logic [2:0] CMD_BLW = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEQ,
    ST_RLAT,
    ST_RDATA,
    ST_WDATA
  } state_t;

  // Block length in words: (sz+1)*8.
  function automatic logic [5:0] burst_len(input logic [1:0] sz);
    logic [5:0] n;
    n = {4'd0, sz} + 6'd1;
    return n << 3;
  endfunction

endpackage

// File: rtl/ddr2_sync_fifo.sv
// ddr2_sync_fifo: single-clock FIFO, push/pop, count/full/empty.
// Ports: clk, reset_n, push, wdata, pop, rdata, count, full, empty.
module ddr2_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only taken when a pop frees the slot.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rp];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

endmodule

// File: rtl/ddr2_host_port_model.sv
// ddr2_host_port_model: command/data responder backed by a word memory,
// returns read data with address and injected ECC error flags.
module ddr2_host_port_model
  import ddr2_host_pkg::*;
#(
  parameter int ADDR_WIDTH  = 25,
  parameter int MEM_AW      = 8,
  parameter int CMD_DEPTH   = 4,
  parameter int DATA_DEPTH  = 32,
  parameter int INIT_CYCLES = 16,
  parameter int READ_LAT    = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  ready,
  output logic                  notfull,
  input  logic                  cmd_put,
  input  logic [2:0]            cmd,
  input  logic [1:0]            sz,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  data_put,
  input  logic [63:0]           data_in,
  input  logic                  fetching,
  output logic                  validout,
  output logic [63:0]           data_out,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic                  ecc_single_err,
  output logic                  ecc_double_err,
  input  logic                  inj_en,
  input  logic [ADDR_WIDTH-1:0] inj_addr,
  input  logic                  inj_double,
  output logic                  busy
);

  localparam int CW = 5 + ADDR_WIDTH;
  localparam int IW = $clog2(INIT_CYCLES + 1);

  logic [63:0] mem [2**MEM_AW];

  logic [CW-1:0]                  cmd_head;
  logic [$clog2(CMD_DEPTH):0]     cmd_count;
  logic                           cmd_full;
  logic                           cmd_empty;
  logic                           cmd_pop;
  logic [63:0]                    data_head;
  logic [$clog2(DATA_DEPTH):0]    data_count;
  logic                           data_full;
  logic                           data_empty;
  logic                           wr;
  logic                           unused_cnt;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [ADDR_WIDTH-1:0]   na;
  logic [5:0]              beats;
  logic [7:0]              lat;
  logic [IW-1:0]           init_cnt;
  logic                    inj_valid;
  logic [ADDR_WIDTH-1:0]   inj_a;
  logic                    inj_dbl;

  logic [2:0]              h_cmd;
  logic [1:0]              h_sz;
  logic [ADDR_WIDTH-1:0]   h_addr;
  logic                    is_rd;
  logic                    is_wr;
  logic                    is_blk;
  logic                    hit;

  assign unused_cnt = ^{cmd_count, data_count};

  assign h_cmd  = cmd_head[CW-1 -: 3];
  assign h_sz   = cmd_head[ADDR_WIDTH+1 -: 2];
  assign h_addr = cmd_head[ADDR_WIDTH-1:0];
  assign is_rd  = (h_cmd == CMD_SCR) || (h_cmd == CMD_BLR);
  assign is_wr  = (h_cmd == CMD_SCW) || (h_cmd == CMD_BLW);
  assign is_blk = (h_cmd == CMD_BLR) || (h_cmd == CMD_BLW);

  assign cmd_pop = (state == ST_DEQ);
  assign wr      = (state == ST_WDATA) && !data_empty;
  assign na      = cur_addr + 1'b1;

  assign notfull = !cmd_full;
  assign busy    = (state != ST_IDLE) || !cmd_empty;

  assign hit = validout && inj_valid && (inj_a == raddr);
  assign ecc_single_err = hit && !inj_dbl;
  assign ecc_double_err = hit && inj_dbl;

  ddr2_sync_fifo #(.W(CW), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (cmd_put && ready),
    .wdata   ({cmd, sz, addr}),
    .pop     (cmd_pop),
    .rdata   (cmd_head),
    .count   (cmd_count),
    .full    (cmd_full),
    .empty   (cmd_empty)
  );

  ddr2_sync_fifo #(.W(64), .DEPTH(DATA_DEPTH)) u_data_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (data_put && ready && !data_full),
    .wdata   (data_in),
    .pop     (wr),
    .rdata   (data_head),
    .count   (data_count),
    .full    (data_full),
    .empty   (data_empty)
  );

  always_ff @(posedge clk) begin
    if (wr) mem[cur_addr[MEM_AW-1:0]] <= data_head;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready     <= 1'b0;
      init_cnt  <= '0;
      state     <= ST_IDLE;
      cur_addr  <= '0;
      beats     <= '0;
      lat       <= '0;
      validout  <= 1'b0;
      data_out  <= '0;
      raddr     <= '0;
      inj_valid <= 1'b0;
      inj_a     <= '0;
      inj_dbl   <= 1'b0;
    end else begin
      if (!ready) begin
        init_cnt <= init_cnt + 1'b1;
        if (init_cnt == IW'(INIT_CYCLES - 1)) ready <= 1'b1;
      end

      // A load on the same cycle as a repairing write takes priority.
      if (inj_en) begin
        inj_valid <= 1'b1;
        inj_a     <= inj_addr;
        inj_dbl   <= inj_double;
      end else if (wr && (cur_addr == inj_a)) begin
        inj_valid <= 1'b0;
      end

      unique case (state)
        ST_IDLE: begin
          if (!cmd_empty) state <= ST_DEQ;
        end
        ST_DEQ: begin
          cur_addr <= h_addr;
          beats    <= is_blk ? burst_len(h_sz) : 6'd1;
          unique case (1'b1)
            is_rd: begin
              if (READ_LAT == 1) begin
                state    <= ST_RDATA;
                validout <= 1'b1;
                data_out <= mem[h_addr[MEM_AW-1:0]];
                raddr    <= h_addr;
              end else begin
                state <= ST_RLAT;
                lat   <= 8'(READ_LAT - 1);
              end
            end
            is_wr:   state <= ST_WDATA;
            default: state <= ST_IDLE;
          endcase
        end
        ST_RLAT: begin
          if (lat == 8'd0) begin
            state    <= ST_RDATA;
            validout <= 1'b1;
            data_out <= mem[cur_addr[MEM_AW-1:0]];
            raddr    <= cur_addr;
          end else begin
            lat <= lat - 8'd1;
          end
        end
        ST_RDATA: begin
          if (validout && fetching) begin
            if (beats == 6'd1) begin
              state    <= ST_IDLE;
              validout <= 1'b0;
            end else begin
              cur_addr <= na;
              beats    <= beats - 6'd1;
              data_out <= mem[na[MEM_AW-1:0]];
              raddr    <= na;
            end
          end
        end
        ST_WDATA: begin
          if (!data_empty) begin
            cur_addr <= na;
            beats    <= beats - 6'd1;
            if (beats == 6'd1) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
